// File: rtl/peak_frame_arbiter.sv
// Purpose : shares one peak detector between two FFT streams, one whole frame at a time, round-robin per frame.
// Latency : 1 cycle from selected channel input to det_* outputs; results burst tagged via o_res_chan.
// Backpr. : none (streams cannot stall); unserviceable sops are dropped and counted, malformed frames aborted.
// Ports   : i_s0_*/i_s1_* channel streams in, o_det_* stream to detector, i_res_valid/i_res_eop detector result
//           handshake, o_res_chan owner of the result burst, o_busy, o_err_len/o_err_tmo pulses, o_drop_cnt0/1.
module peak_frame_arbiter #(
  parameter int SIZE    = 1024,
  parameter int WIDTH   = 24,
  parameter int TIMEOUT = 4096
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_s0_sop,
  input  logic             i_s0_eop,
  input  logic             i_s0_valid,
  input  logic [WIDTH-1:0] i_s0_mag,
  input  logic [15:0]      i_s0_phase,
  input  logic             i_s1_sop,
  input  logic             i_s1_eop,
  input  logic             i_s1_valid,
  input  logic [WIDTH-1:0] i_s1_mag,
  input  logic [15:0]      i_s1_phase,
  output logic             o_det_sop,
  output logic             o_det_eop,
  output logic             o_det_valid,
  output logic [WIDTH-1:0] o_det_mag,
  output logic [15:0]      o_det_phase,
  input  logic             i_res_valid,
  input  logic             i_res_eop,
  output logic             o_res_chan,
  output logic             o_busy,
  output logic             o_err_len,
  output logic             o_err_tmo,
  output logic [7:0]       o_drop_cnt0,
  output logic [7:0]       o_drop_cnt1
);

  localparam int CW = $clog2(SIZE) + 1;
  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] C_SIZE     = CW'(SIZE);
  localparam logic [WW-1:0] C_TMO_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FWD = 2'd1, S_WAIT = 2'd2} state_t;

  state_t           r_state, w_state_n;
  logic             r_sel, r_last, r_res_chan;
  logic [CW-1:0]    r_cnt;
  logic [WW-1:0]    r_wcnt;
  logic [7:0]       r_drop0, r_drop1;
  logic             r_det_sop, r_det_eop, r_det_vld;
  logic [WIDTH-1:0] r_det_mag;
  logic [15:0]      r_det_phase;
  logic             r_err_len, r_err_tmo;

  logic             w_req0, w_req1;
  logic             w_cur_vld, w_cur_sop, w_cur_eop;
  logic [CW-1:0]    w_cnt_inc;
  logic             w_grant, w_grant_ch, w_fwd, w_abort, w_short, w_full, w_tmo;
  logic             w_drop0, w_drop1;
  logic             w_det_sop_n, w_det_eop_n, w_det_vld_n;
  logic [WIDTH-1:0] w_det_mag_n;
  logic [15:0]      w_det_phase_n;

  assign w_req0    = i_s0_valid & i_s0_sop;
  assign w_req1    = i_s1_valid & i_s1_sop;
  assign w_cur_vld = r_sel ? i_s1_valid : i_s0_valid;
  assign w_cur_sop = r_sel ? i_s1_sop   : i_s0_sop;
  assign w_cur_eop = r_sel ? i_s1_eop   : i_s0_eop;
  assign w_cnt_inc = r_cnt + CW'(1);

  // State register plus the counters and registered outputs it governs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_sel       <= 1'b0;
      r_last      <= 1'b1;
      r_res_chan  <= 1'b0;
      r_cnt       <= '0;
      r_wcnt      <= '0;
      r_drop0     <= 8'd0;
      r_drop1     <= 8'd0;
      r_det_sop   <= 1'b0;
      r_det_eop   <= 1'b0;
      r_det_vld   <= 1'b0;
      r_det_mag   <= '0;
      r_det_phase <= '0;
      r_err_len   <= 1'b0;
      r_err_tmo   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      if (w_grant) begin
        r_sel      <= w_grant_ch;
        r_res_chan <= w_grant_ch;
        r_cnt      <= CW'(1);
      end else if (w_fwd) begin
        r_cnt <= w_cnt_inc;
      end
      // Only a complete frame counts as "served" for the round-robin tie-break.
      if (w_full) r_last <= w_grant_ch;
      r_wcnt <= (r_state == S_WAIT) ? r_wcnt + WW'(1) : '0;
      if (w_drop0 && r_drop0 != 8'hFF) r_drop0 <= r_drop0 + 8'd1;
      if (w_drop1 && r_drop1 != 8'hFF) r_drop1 <= r_drop1 + 8'd1;
      r_det_sop   <= w_det_sop_n;
      r_det_eop   <= w_det_eop_n;
      r_det_vld   <= w_det_vld_n;
      r_det_mag   <= w_det_mag_n;
      r_det_phase <= w_det_phase_n;
      r_err_len   <= w_short | w_abort;
      r_err_tmo   <= w_tmo;
    end
  end

  // Next-state and event decode.
  always_comb begin
    w_state_n  = r_state;
    w_grant    = 1'b0;
    w_grant_ch = r_sel;
    w_fwd      = 1'b0;
    w_abort    = 1'b0;
    w_short    = 1'b0;
    w_full     = 1'b0;
    w_tmo      = 1'b0;
    w_drop0    = 1'b0;
    w_drop1    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req0 && w_req1) begin
          // Tie: the channel not served last wins, the other is dropped.
          w_grant    = 1'b1;
          w_grant_ch = ~r_last;
          w_drop0    = ~r_last;
          w_drop1    = r_last;
        end else if (w_req0) begin
          w_grant    = 1'b1;
          w_grant_ch = 1'b0;
        end else if (w_req1) begin
          w_grant    = 1'b1;
          w_grant_ch = 1'b1;
        end
        if (w_grant) begin
          if (w_grant_ch ? i_s1_eop : i_s0_eop) begin
            // Single-beat frame: complete only when SIZE is 1.
            if (SIZE == 1) begin
              w_full    = 1'b1;
              w_state_n = S_WAIT;
            end else begin
              w_short = 1'b1;
            end
          end else begin
            w_state_n = S_FWD;
          end
        end
      end
      S_FWD: begin
        if (r_sel) w_drop0 = w_req0;
        else       w_drop1 = w_req1;
        if (w_cur_vld) begin
          // r_cnt == SIZE means the frame is already full and this beat has no place in it.
          if (w_cur_sop || r_cnt == C_SIZE) begin
            w_abort   = 1'b1;
            w_state_n = S_IDLE;
          end else begin
            w_fwd = 1'b1;
            if (w_cur_eop) begin
              if (w_cnt_inc == C_SIZE) begin
                w_full    = 1'b1;
                w_state_n = S_WAIT;
              end else begin
                w_short   = 1'b1;
                w_state_n = S_IDLE;
              end
            end
          end
        end
      end
      S_WAIT: begin
        w_drop0 = w_req0;
        w_drop1 = w_req1;
        if (i_res_valid && i_res_eop) begin
          w_state_n = S_IDLE;
        end else if (r_wcnt == C_TMO_LAST) begin
          w_tmo     = 1'b1;
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Next value of the detector-side stream registers.
  always_comb begin
    w_det_vld_n   = 1'b0;
    w_det_sop_n   = 1'b0;
    w_det_eop_n   = 1'b0;
    w_det_mag_n   = '0;
    w_det_phase_n = '0;
    if (w_grant || w_fwd) begin
      w_det_vld_n = 1'b1;
      if ((w_grant && w_grant_ch) || (!w_grant && r_sel)) begin
        w_det_sop_n   = i_s1_sop;
        w_det_eop_n   = i_s1_eop;
        w_det_mag_n   = i_s1_mag;
        w_det_phase_n = i_s1_phase;
      end else begin
        w_det_sop_n   = i_s0_sop;
        w_det_eop_n   = i_s0_eop;
        w_det_mag_n   = i_s0_mag;
        w_det_phase_n = i_s0_phase;
      end
    end
    // Abort closes the partial frame with a data-less eop so the detector resets.
    if (w_abort) w_det_eop_n = 1'b1;
  end

  assign o_det_sop   = r_det_sop;
  assign o_det_eop   = r_det_eop;
  assign o_det_valid = r_det_vld;
  assign o_det_mag   = r_det_mag;
  assign o_det_phase = r_det_phase;
  assign o_res_chan  = r_res_chan;
  assign o_busy      = (r_state != S_IDLE);
  assign o_err_len   = r_err_len;
  assign o_err_tmo   = r_err_tmo;
  assign o_drop_cnt0 = r_drop0;
  assign o_drop_cnt1 = r_drop1;

endmodule

// File: tb/tb_peak_frame_arbiter.sv
module tb_peak_frame_arbiter;
  localparam int SIZE    = 1024;
  localparam int WIDTH   = 24;
  localparam int TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             s0_sop, s0_eop, s0_valid, s1_sop, s1_eop, s1_valid;
  logic [WIDTH-1:0] s0_mag, s1_mag;
  logic [15:0]      s0_phase, s1_phase;
  logic             res_valid, res_eop;
  logic             det_sop, det_eop, det_valid, res_chan, busy, err_len, err_tmo;
  logic [WIDTH-1:0] det_mag;
  logic [15:0]      det_phase;
  logic [7:0]       drop_cnt0, drop_cnt1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  peak_frame_arbiter #(.SIZE(SIZE), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_s0_sop(s0_sop), .i_s0_eop(s0_eop), .i_s0_valid(s0_valid), .i_s0_mag(s0_mag), .i_s0_phase(s0_phase),
    .i_s1_sop(s1_sop), .i_s1_eop(s1_eop), .i_s1_valid(s1_valid), .i_s1_mag(s1_mag), .i_s1_phase(s1_phase),
    .o_det_sop(det_sop), .o_det_eop(det_eop), .o_det_valid(det_valid), .o_det_mag(det_mag),
    .o_det_phase(det_phase), .i_res_valid(res_valid), .i_res_eop(res_eop), .o_res_chan(res_chan),
    .o_busy(busy), .o_err_len(err_len), .o_err_tmo(err_tmo),
    .o_drop_cnt0(drop_cnt0), .o_drop_cnt1(drop_cnt1)
  );

  typedef struct {
    logic        s0_sop, s0_eop, s0_vld;
    logic [23:0] s0_mag;
    logic        s1_sop, s1_eop, s1_vld;
    logic [23:0] s1_mag;
    logic        x_vld, x_sop, x_eop;
    logic [23:0] x_mag;
    logic        x_busy, x_err, x_chan;
    logic [7:0]  x_drop0, x_drop1;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [15:0] phs0(input logic [23:0] m);
    return m[15:0] ^ 16'hA5C3;
  endfunction

  function automatic logic [15:0] phs1(input logic [23:0] m);
    return m[15:0] ^ 16'h3C5A;
  endfunction

  // {valid, sop, eop, busy, err_len, mag, phase}
  function automatic logic [63:0] dexp(input logic v, s, e, b, er, input logic [23:0] m, input logic [15:0] p);
    return {19'd0, v, s, e, b, er, m, p};
  endfunction

  function automatic logic [63:0] dact();
    return {19'd0, det_valid, det_sop, det_eop, busy, err_len, det_mag, det_phase};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic sop, eop, vld, input logic [23:0] m);
    s0_sop = sop; s0_eop = eop; s0_valid = vld; s0_mag = m; s0_phase = phs0(m);
  endtask

  task automatic drv1(input logic sop, eop, vld, input logic [23:0] m);
    s1_sop = sop; s1_eop = eop; s1_valid = vld; s1_mag = m; s1_phase = phs1(m);
  endtask

  task automatic clr();
    drv0(1'b0, 1'b0, 1'b0, 24'd0);
    drv1(1'b0, 1'b0, 1'b0, 24'd0);
    res_valid = 1'b0;
    res_eop   = 1'b0;
  endtask

  task automatic do_reset();
    clr();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Full-length ch0 frame; only the closing eop beat is checked here.
  task automatic full_frame0(input string name);
    for (int i = 0; i < SIZE; i++) begin
      drv0(i == 0, i == SIZE - 1, 1'b1, 24'(i));
      drv1(1'b0, 1'b0, 1'b0, 24'd0);
      tick();
      if (i == SIZE - 1)
        chk(name, dact(), dexp(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24'(i), phs0(24'(i))));
    end
    clr();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1,1'b0,1'b1,24'd7,  1'b1,1'b0,1'b1,24'd9,  1'b1,1'b1,1'b0,24'd7,  1'b1,1'b0,1'b0, 8'd0,8'd1};
    vecs[1] = '{1'b0,1'b0,1'b1,24'd8,  1'b0,1'b0,1'b1,24'd99, 1'b1,1'b0,1'b0,24'd8,  1'b1,1'b0,1'b0, 8'd0,8'd1};
    vecs[2] = '{1'b0,1'b0,1'b0,24'd0,  1'b1,1'b0,1'b1,24'd5,  1'b0,1'b0,1'b0,24'd0,  1'b1,1'b0,1'b0, 8'd0,8'd2};
    vecs[3] = '{1'b1,1'b0,1'b1,24'd11, 1'b0,1'b0,1'b0,24'd0,  1'b0,1'b0,1'b1,24'd0,  1'b0,1'b1,1'b0, 8'd0,8'd2};
    vecs[4] = '{1'b1,1'b0,1'b1,24'd12, 1'b1,1'b0,1'b1,24'd13, 1'b1,1'b1,1'b0,24'd12, 1'b1,1'b0,1'b0, 8'd0,8'd3};

    // Reset state, sampled while reset is still asserted.
    clr();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_det", dact(), 64'd0);
    chk("rst_chan", 64'(res_chan), 64'd0);
    chk("rst_tmo", 64'(err_tmo), 64'd0);
    chk("rst_drop0", 64'(drop_cnt0), 64'd0);
    chk("rst_drop1", 64'(drop_cnt1), 64'd0);
    reset = 1'b0;

    // Full ch0 frame, mag = bin index, then a 4-beat result burst.
    for (int i = 0; i < SIZE; i++) begin
      drv0(i == 0, i == SIZE - 1, 1'b1, 24'(i));
      tick();
      chk($sformatf("t1_beat%0d", i), dact(),
          dexp(1'b1, i == 0, i == SIZE - 1, 1'b1, 1'b0, 24'(i), phs0(24'(i))));
    end
    clr();
    for (int k = 0; k < 4; k++) begin
      res_valid = 1'b1;
      res_eop   = (k == 3);
      tick();
      chk($sformatf("t1_res%0d_chan", k), 64'(res_chan), 64'd0);
      chk($sformatf("t1_res%0d_det", k), dact(), dexp(1'b0, 1'b0, 1'b0, k != 3, 1'b0, 24'd0, 16'd0));
    end
    clr();

    // Tie-break, drops, sop-mid-frame abort (table driven).
    do_reset();
    for (int r = 0; r < 5; r++) begin
      vec_t v;
      v = vecs[r];
      drv0(v.s0_sop, v.s0_eop, v.s0_vld, v.s0_mag);
      drv1(v.s1_sop, v.s1_eop, v.s1_vld, v.s1_mag);
      tick();
      chk($sformatf("t2_row%0d_det", r), dact(),
          dexp(v.x_vld, v.x_sop, v.x_eop, v.x_busy, v.x_err, v.x_mag,
               v.x_vld ? (v.x_chan ? phs1(v.x_mag) : phs0(v.x_mag)) : 16'h0));
      chk($sformatf("t2_row%0d_chan", r), 64'(res_chan), 64'(v.x_chan));
      chk($sformatf("t2_row%0d_drop0", r), 64'(drop_cnt0), 64'(v.x_drop0));
      chk($sformatf("t2_row%0d_drop1", r), 64'(drop_cnt1), 64'(v.x_drop1));
    end
    // Finish ch0's frame (sop was row 4) so ch0 becomes last-served.
    for (int i = 1; i < SIZE; i++) begin
      drv0(1'b0, i == SIZE - 1, 1'b1, 24'(i));
      drv1(1'b0, 1'b0, 1'b0, 24'd0);
      tick();
      if (i == SIZE - 1)
        chk("t2_eop", dact(), dexp(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24'(i), phs0(24'(i))));
    end
    clr();
    res_valid = 1'b1;
    res_eop   = 1'b1;
    tick();
    clr();
    chk("t2_idle_busy", 64'(busy), 64'd0);
    drv0(1'b1, 1'b0, 1'b1, 24'd21);
    drv1(1'b1, 1'b0, 1'b1, 24'd22);
    tick();
    chk("t2_tie2_det", dact(), dexp(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 24'd22, phs1(24'd22)));
    chk("t2_tie2_chan", 64'(res_chan), 64'd1);
    chk("t2_tie2_drop0", 64'(drop_cnt0), 64'd1);
    chk("t2_tie2_drop1", 64'(drop_cnt1), 64'd3);

    // Short ch0 frame: eop on beat 500.
    do_reset();
    for (int i = 0; i <= 500; i++) begin
      drv0(i == 0, i == 500, 1'b1, 24'(i + 100));
      tick();
      chk($sformatf("t3_beat%0d", i), dact(),
          dexp(1'b1, i == 0, i == 500, i != 500, i == 500, 24'(i + 100), phs0(24'(i + 100))));
    end
    clr();
    tick();
    chk("t3_after", dact(), 64'd0);

    // ch1 frame of 1030 beats with no eop; a ch0 sop mid-frame is dropped.
    do_reset();
    for (int i = 0; i < 1030; i++) begin
      drv1(i == 0, 1'b0, 1'b1, 24'(i + 3));
      if (i == 10) drv0(1'b1, 1'b0, 1'b1, 24'd55);
      else         drv0(1'b0, 1'b0, 1'b0, 24'd0);
      tick();
      if (i < SIZE)
        chk($sformatf("t4_beat%0d", i), dact(),
            dexp(1'b1, i == 0, 1'b0, 1'b1, 1'b0, 24'(i + 3), phs1(24'(i + 3))));
      else if (i == SIZE)
        chk("t4_abort", dact(), dexp(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 24'd0, 16'd0));
      else
        chk($sformatf("t4_ignored%0d", i), dact(), 64'd0);
    end
    clr();
    chk("t4_drop0", 64'(drop_cnt0), 64'd1);
    chk("t4_chan", 64'(res_chan), 64'd1);

    // Result timeout: 64 cycles in WAIT_RES with no res_eop.
    do_reset();
    full_frame0("t5_eop");
    for (int k = 1; k <= 66; k++) begin
      clr();
      if (k == 5) drv1(1'b1, 1'b0, 1'b1, 24'd1);
      if (k == 6) res_valid = 1'b1;
      tick();
      if (k >= 60) begin
        chk($sformatf("t5_tmo_k%0d", k), 64'(err_tmo), 64'(k == 64));
        chk($sformatf("t5_busy_k%0d", k), 64'(busy), 64'(k < 64));
      end
    end
    clr();
    chk("t5_drop1", 64'(drop_cnt1), 64'd1);

    // Drop saturation while ch0 holds the detector, then reset mid-frame.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drv0(i == 0, 1'b0, 1'b1, 24'(i));
      drv1(i >= 1 && i <= 300, 1'b0, i >= 1 && i <= 300, 24'd0);
      tick();
      if (i == 150) chk("t6_drop1_150", 64'(drop_cnt1), 64'd150);
      if (i == 300) chk("t6_drop1_sat", 64'(drop_cnt1), 64'd255);
    end
    chk("t6_fwd_det", dact(), dexp(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'd399, phs0(24'd399)));
    drv1(1'b0, 1'b0, 1'b0, 24'd0);
    drv0(1'b0, 1'b0, 1'b1, 24'd400);
    reset = 1'b1;
    tick();
    chk("t6_rst_det", dact(), 64'd0);
    chk("t6_rst_drop1", 64'(drop_cnt1), 64'd0);
    chk("t6_rst_tmo", 64'(err_tmo), 64'd0);
    reset = 1'b0;
    drv0(1'b0, 1'b0, 1'b1, 24'd401);
    tick();
    chk("t6_post_rst", dact(), 64'd0);
    clr();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/peak_frame_arbiter.md
Name: peak_frame_arbiter

Overview:
Shares one peak detector between two FFT magnitude/phase streams (channel 0, channel 1). Locks onto one channel per frame, forwards that frame to the detector, then waits for the detector's result burst before granting the next frame. Arbitration is round-robin per frame. The block tags results with the channel number, drops and counts frames it cannot serve, and aborts malformed frames. Sits between the two FFT cores and the peak detector sink.

Parameters:
SIZE, 1024, FFT bins per frame (beats from sop to eop inclusive)
WIDTH, 24, magnitude width (UQ<WIDTH>.0)
TIMEOUT, 4096, max cycles in WAIT_RES before giving up

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
s0_sop, s0_eop, s0_valid  in  1 each  channel 0 frame strobes (no backpressure)
s0_mag  in  WIDTH  channel 0 magnitude, UQ<WIDTH>.0
s0_phase  in  16  channel 0 phase, Q3.13
s1_sop, s1_eop, s1_valid, s1_mag, s1_phase  in  as channel 0  channel 1 stream
det_sop, det_eop, det_valid  out  1 each  strobes to detector sink
det_mag  out  WIDTH  magnitude to detector
det_phase  out  16  phase to detector
res_valid  in  1  detector source_valid
res_eop  in  1  detector source_eop
res_chan  out  1  channel owning the current result burst
busy  out  1  high when state != IDLE
err_len  out  1  one-cycle pulse on frame abort (length error)
err_tmo  out  1  one-cycle pulse on result timeout
drop_cnt0, drop_cnt1  out  8 each  dropped-frame counters, saturating

Behaviour:
- Reset values: all det_* = 0, res_chan = 0, busy = 0, err_len = 0, err_tmo = 0, drop counters = 0, state = IDLE, last-served = 1 (channel 0 wins the first tie). Reset mid-frame or mid-wait goes to IDLE immediately. No det_eop is emitted on reset.
- States: IDLE, FWD, WAIT_RES.
- IDLE:
  - A valid&&sop on a channel grants it. sel := channel, res_chan := channel, beat count := 1, state := FWD.
  - If both channels present sop in the same cycle, the channel != last-served wins. The loser's drop counter increments.
  - The sop beat is forwarded.
- Forwarding: one-cycle registered latency. det_* in cycle n+1 equal the selected channel's inputs in cycle n. Cycles with the selected channel's valid low produce det_valid = 0 with flags 0.
- FWD, on each valid beat of the selected channel:
  - Forward the beat and increment the count.
  - eop with count == SIZE: forward it, set last-served := sel, state := WAIT_RES, wait count := 0.
  - eop with count < SIZE (short frame): forward it (the detector resets on eop), pulse err_len, state := IDLE.
  - count reaches SIZE without eop, or a sop arrives mid-frame: emit det_eop = 1, det_valid = 0 on the next cycle, pulse err_len, state := IDLE. The offending beat is not forwarded.
- WAIT_RES:
  - No det_valid. res_chan is held.
  - res_valid && res_eop: state := IDLE in the next cycle.
  - The wait counter reaching TIMEOUT-1: pulse err_tmo, state := IDLE.
- Drops: a valid&&sop on the non-granted channel in any state, or on either channel while in WAIT_RES, increments that channel's drop counter. Counters saturate at 255.
- A new grant is possible in the cycle after returning to IDLE; back-to-back frames are not merged.
- Widths: the beat counter is $clog2(SIZE)+1 bits. The wait counter is $clog2(TIMEOUT)+1 bits.

Test Plan:
- Reset, then a 1024-beat frame on ch0 with mag = bin index -> det_mag equals input delayed by 1 cycle, det_sop on beat 0, det_eop on beat 1023, busy high. Then 4 res_valid beats with res_eop on the 4th -> res_chan = 0 throughout, busy low the cycle after.
- s0_sop and s1_sop in the same cycle after reset -> ch0 forwarded, drop_cnt1 = 1. Repeat the tie after ch0's results -> ch1 granted, drop_cnt0 = 1.
- ch0 frame with eop at beat 500 -> eop forwarded at beat 500, err_len pulse, IDLE; no WAIT_RES.
- ch1 frame of 1030 beats with no eop -> beats 0..1023 forwarded, then det_eop = 1 with det_valid = 0, err_len pulse; beats 1024+ ignored.
- Full frame with no results returned, TIMEOUT = 64 -> err_tmo after 64 cycles in WAIT_RES, then IDLE.
- 300 ch1 sops while ch0 is always busy -> drop_cnt1 saturates at 255. Assert reset mid-FWD -> all outputs 0 the next cycle, counters cleared.
